// File: rtl/sram_responder.sv
// SRAM responder for the SLC-3 external memory bus.
// It fills the whole array with INIT_WORD after reset, then serves byte-masked writes and registered reads.
module sram_responder #(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [15:0] INIT_WORD = 16'h0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        CE,
  input  logic        UB,
  input  logic        LB,
  input  logic        OE,
  input  logic        WE,
  input  logic [19:0] ADDR,
  inout  wire  [15:0] Data,
  output logic        Ready
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned DATA_W = 16;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    INIT,
    SERVE
  } state_t;

  state_t              state_q;
  state_t              next_state;
  logic [ADDR_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_valid_q;
  logic                rd_hi_q;
  logic                rd_lo_q;
  logic                ready_q;
  logic                init_we_c;
  logic                wr_hi_c;
  logic                wr_lo_c;
  logic                rd_en_c;
  logic                unused_addr_c;

  // Upper address bits alias onto the implemented array.
  assign addr          = ADDR[ADDR_W-1:0];
  assign unused_addr_c = ^ADDR[19:ADDR_W];

  // Next-state and access decode; everything is gated off while Reset is sampled high.
  always_comb begin
    next_state = state_q;
    init_we_c  = 1'b0;
    wr_hi_c    = 1'b0;
    wr_lo_c    = 1'b0;
    rd_en_c    = 1'b0;
    if (Reset) begin
      next_state = INIT;
    end else begin
      case (state_q)
        INIT: begin
          init_we_c = 1'b1;
          if (cnt_q == LAST_ADDR) next_state = SERVE;
        end
        SERVE: begin
          if (!CE && !WE) begin
            wr_hi_c = !UB;
            wr_lo_c = !LB;
          end else if (!CE && !OE) begin
            rd_en_c = 1'b1;
          end
        end
        default: next_state = INIT;
      endcase
    end
  end

  // Control state, init counter and read-lane qualifiers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_hi_q    <= 1'b0;
      rd_lo_q    <= 1'b0;
    end else begin
      state_q    <= next_state;
      ready_q    <= (next_state == SERVE);
      rd_valid_q <= rd_en_c;
      if (init_we_c) cnt_q <= cnt_q + ADDR_W'(1);
      if (rd_en_c) begin
        rd_hi_q <= !UB;
        rd_lo_q <= !LB;
      end
    end
  end

  // Storage array and read-data register; a write is visible to a read on the next edge.
  always_ff @(posedge Clk) begin
    if (init_we_c) mem[cnt_q] <= INIT_WORD;
    if (wr_hi_c)   mem[addr][15:8] <= Data[15:8];
    if (wr_lo_c)   mem[addr][7:0]  <= Data[7:0];
    if (rd_en_c)   rd_data_q <= mem[addr];
  end

  assign Ready      = ready_q;
  assign Data[15:8] = (rd_valid_q && rd_hi_q) ? rd_data_q[15:8] : 8'bzzzz_zzzz;
  assign Data[7:0]  = (rd_valid_q && rd_lo_q) ? rd_data_q[7:0]  : 8'bzzzz_zzzz;

endmodule

// File: doc/sram_responder.md
# sram_responder

Synthesizable, bus-accurate responder for the SLC-3 external SRAM interface. It sits on the far side of the CE/UB/LB/OE/WE/ADDR/Data bus driven by the processor's memory controller. It answers reads on the bidirectional Data bus and commits byte-masked writes. After every reset it walks the whole array to a known pattern, so simulation and FPGA builds start from identical memory contents.

## Interface
Parameters:
- ADDR_W, 10, implemented address bits; depth = 2**ADDR_W words; ADDR[19:ADDR_W] ignored (aliasing)
- INIT_WORD, 16'h0000, value written to every word during post-reset initialization

Ports:
- Clk  input  1  system clock; all state changes on rising edge
- Reset  input  1  synchronous, active-high reset
- CE  input  1  chip enable, active-low
- UB  input  1  upper-byte (Data[15:8]) enable, active-low
- LB  input  1  lower-byte (Data[7:0]) enable, active-low
- OE  input  1  output enable, active-low
- WE  input  1  write enable, active-low
- ADDR  input  20  word address
- Data  inout  16  bidirectional data; driven only by the read path, high-Z otherwise
- Ready  output  1  high once initialization is complete; bus accesses are honoured only while Ready=1

## Operation
- States: INIT, SERVE.
- Reset=1: state←INIT, init counter←0, Ready←0, read-valid register←0, Data high-Z.
- INIT: each cycle writes INIT_WORD to mem[counter] and increments the counter. After address 2**ADDR_W−1 is written, state←SERVE and Ready←1. Total INIT duration is exactly 2**ADDR_W cycles after Reset falls. Bus inputs are ignored and Data stays high-Z.
- SERVE, per rising edge, decode the sampled controls:
  - Write: CE=0 & WE=0. mem[ADDR[ADDR_W-1:0]] upper byte←Data[15:8] if UB=0; lower byte←Data[7:0] if LB=0. OE is don't-care because WE overrides OE. No read is issued.
  - Read: CE=0 & WE=1 & OE=0. Read-data register←mem[addr]. Registered lane enables ←(~UB, ~LB). Read-valid←1.
  - Otherwise: read-valid←0.
- Data drive is purely from registers: Data[15:8] = rd_data[15:8] when read-valid & hi-enable, else Z; Data[7:0] likewise with lo-enable.
- UB=LB=1 on a write means no byte changes. UB=LB=1 on a read leaves both lanes Z for that cycle.
- Reset asserted mid-INIT restarts INIT from address 0. Reset asserted in SERVE drops Ready the next edge and re-initializes the whole array.

## Timing
- Read latency 1 cycle. Controls and address sampled at edge N; Data valid from just after edge N and held through edge N+1. Back-to-back reads pipeline at 1 word per cycle.
- Write commits at the sampling edge. A read of the same address sampled at the next edge returns the new value (no stale read).
- Read followed immediately by write: Data stops being driven right after the write's sampling edge (read-valid←0). The controller must not drive Data during the cycle the responder drives it. The responder never drives Data in a cycle after sampling WE=0.
- All outputs are registered. No combinational path from ADDR, the control inputs, or Data to Data or Ready.
- Reset values: Ready=0, Data=16'hZZZZ.

## Test plan
- Init: ADDR_W=4, INIT_WORD=16'hA5A5. Deassert Reset and count cycles until Ready=1 → exactly 16. Then read every address → 16'hA5A5 each.
- Full-word write/read: write 16'h1234 to ADDR=3 (UB=LB=0), then read ADDR=3 the next cycle → Data=16'h1234 one cycle after sampling. Read ADDR=3+16 (alias) → 16'h1234.
- Byte masking: over 16'hA5A5, write 16'hBEEF with UB=1, LB=0 → read 16'hA5EF. Write 16'h0000 with UB=0, LB=1 → read 16'h00EF. Read with UB=1, LB=0 → Data[15:8]=Z, Data[7:0]=8'hEF.
- Contention: CE=0, OE=0, WE=0 with Data=16'h5555 at ADDR=7 → no drive that cycle; a following read returns 16'h5555. CE=1 with any other inputs → no state change and Data=Z.
- Pipelined reads: reads of ADDR 0,1,2 on consecutive edges → Data sequence mem[0], mem[1], mem[2] on consecutive cycles, no gaps.
- Reset mid-operation: write 16'hDEAD to ADDR=5, pulse Reset at INIT cycle 8, and let INIT complete → Ready high 16 cycles after Reset falls and ADDR=5 reads INIT_WORD.
